// File: rtl/dmem_sized.sv
// dmem_sized: big-endian byte/half/word data memory with wait-state handshake.
// Optional DMEM_CLEAR_EN: zero the whole array, one word per cycle, after reset.
module dmem_sized #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       read_data
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW    = (AW > 2) ? AW - 2 : 1;

    localparam logic [3:0] WAIT_N  = 4'(WAIT_CYCLES);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [1:0]    size;
        logic          uns;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } req_t;

`ifdef DMEM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WAIT, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_BYTES - 4);
`else
    typedef enum logic [1:0] {IDLE, WAIT} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t        state;
    state_t        stateNext;
    logic [3:0]    count;
    logic [3:0]    countNext;
    logic          reqFire;
    logic          accessNow;
    req_t          live;
    req_t          held;
    req_t          cur;
    logic [AW-1:0] ea;
    logic          accErr;
    logic [IW-1:0] idx;
    logic [31:0]   rWord;
    logic [7:0]    byteVal;
    logic [15:0]   halfVal;
    logic [31:0]   wordVal;
    logic [31:0]   loadVal;
    logic [3:0]    wBe;
    logic [IW-1:0] wIdx;
    logic [31:0]   wWord;
    logic [31:0]   mem [WORDS];

`ifdef DMEM_CLEAR_EN
    logic          clrWrite;
    logic [AW-1:0] clrAddr;
    logic [AW-1:0] clrAddrNext;
`endif

    // Address bits above the array size alias onto it and are dropped.
    if (ADDR_W > AW) begin : gHighAddr
        logic unusedHighAddr;
        assign unusedHighAddr = ^address[ADDR_W-1:AW];
    end

    assign reqFire = mem_read | mem_write;

    assign live = '{
        rd:   mem_read,
        wr:   mem_write,
        size: mem_size,
        uns:  mem_unsigned,
        addr: address[AW-1:0],
        wd:   write_data
    };

    // Zero wait states act on the live request; otherwise on the held copy.
    assign cur = (WAIT_N == 4'd0) ? live : held;
    assign ea  = cur.addr;
    assign idx = IW'(ea >> 2);

    // Next state, countdown and handshake outputs.
    always_comb begin
        stateNext = state;
        countNext = count;
        req_ready = 1'b0;
        accessNow = 1'b0;
`ifdef DMEM_CLEAR_EN
        clrWrite    = 1'b0;
        clrAddrNext = clrAddr;
`endif
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (reqFire) begin
                    if (WAIT_N == 4'd0) begin
                        accessNow = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        countNext = WAIT_N;
                    end
                end
            end
            WAIT: begin
                countNext = count - 4'd1;
                if (count == 4'd1) begin
                    accessNow = 1'b1;
                    stateNext = IDLE;
                end
            end
`ifdef DMEM_CLEAR_EN
            CLEAR: begin
                clrWrite    = 1'b1;
                clrAddrNext = clrAddr + AW'(4);
                if (clrAddr == LAST_WORD) begin
                    stateNext = IDLE;
                end
            end
`endif
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register; reset drops any access still counting down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            count <= 4'd0;
`ifdef DMEM_CLEAR_EN
            clrAddr <= '0;
`endif
        end else begin
            state <= stateNext;
            count <= countNext;
`ifdef DMEM_CLEAR_EN
            clrAddr <= clrAddrNext;
`endif
        end
    end

    // Capture the request at the accept edge for the wait-state path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (req_ready && reqFire) begin
            held <= live;
        end
    end

    // Alignment check: half needs an even address, word needs a multiple of 4.
    always_comb begin
        accErr = 1'b0;
        unique case (cur.size)
            SZ_BYTE: accErr = 1'b0;
            SZ_HALF: accErr = ea[0];
            SZ_WORD: accErr = |ea[1:0];
            default: accErr = 1'b1;
        endcase
    end

    assign rWord = mem[idx];

    // Load formatting; a store in the same request supplies the data.
    always_comb begin
        byteVal = 8'd0;
        halfVal = 16'd0;
        wordVal = rWord;
        loadVal = 32'd0;
        unique case (ea[1:0])
            2'd0:    byteVal = rWord[31:24];
            2'd1:    byteVal = rWord[23:16];
            2'd2:    byteVal = rWord[15:8];
            default: byteVal = rWord[7:0];
        endcase
        halfVal = ea[1] ? rWord[15:0] : rWord[31:16];
        if (cur.wr) begin
            byteVal = cur.wd[7:0];
            halfVal = cur.wd[15:0];
            wordVal = cur.wd;
        end
        unique case (cur.size)
            SZ_BYTE: begin
                loadVal = cur.uns ? {24'd0, byteVal}
                                  : {{24{byteVal[7]}}, byteVal};
            end
            SZ_HALF: begin
                loadVal = cur.uns ? {16'd0, halfVal}
                                  : {{16{halfVal[15]}}, halfVal};
            end
            default: begin
                loadVal = wordVal;
            end
        endcase
    end

    // Byte-lane enables; lane 3 is the lowest address (big-endian).
    always_comb begin
        wBe   = 4'b0000;
        wIdx  = idx;
        wWord = cur.wd;
        if (accessNow && cur.wr && !accErr) begin
            unique case (cur.size)
                SZ_BYTE: begin
                    wBe   = 4'b1000 >> ea[1:0];
                    wWord = {4{cur.wd[7:0]}};
                end
                SZ_HALF: begin
                    wBe   = 4'b1100 >> ea[1:0];
                    wWord = {2{cur.wd[15:0]}};
                end
                SZ_WORD: begin
                    wBe = 4'b1111;
                end
                default: begin
                    wBe = 4'b0000;
                end
            endcase
        end
`ifdef DMEM_CLEAR_EN
        if (clrWrite) begin
            wBe   = 4'b1111;
            wIdx  = IW'(clrAddr >> 2);
            wWord = 32'd0;
        end
`endif
        if (!rst_n) begin
            wBe = 4'b0000;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wBe[b]) begin
                mem[wIdx][8*b +: 8] <= wWord[8*b +: 8];
            end
        end
    end

    // Response strobe and load result; read_data holds across write-only responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            read_data  <= 32'd0;
        end else begin
            resp_valid <= accessNow;
            resp_err   <= accessNow & accErr;
            if (accessNow) begin
                if (accErr) begin
                    read_data <= 32'd0;
                end else if (cur.rd) begin
                    read_data <= loadVal;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: random and directed checks of dmem_sized at 0 and 3 wait states.
// A byte-array model predicts every response from the access rules.
module tb_dmem_sized;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        memRead[2];
    logic        memWrite[2];
    logic [1:0]  memSize[2];
    logic        memUnsigned[2];
    logic [31:0] address[2];
    logic [31:0] writeData[2];
    logic        reqReady[2];
    logic        respValid[2];
    logic        respErr[2];
    logic [31:0] readData[2];

    int          checks = 0;
    int          failures = 0;

    int          model[2][DEPTH];
    bit          known[2][DEPTH];
    logic [31:0] lastData[2];
    bit          lastKnown[2];

    dmem_sized #(
        .ADDR_W(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(memRead[0]), .mem_write(memWrite[0]),
        .mem_size(memSize[0]), .mem_unsigned(memUnsigned[0]),
        .address(address[0]), .write_data(writeData[0]),
        .req_ready(reqReady[0]), .resp_valid(respValid[0]),
        .resp_err(respErr[0]), .read_data(readData[0])
    );

    dmem_sized #(
        .ADDR_W(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(memRead[1]), .mem_write(memWrite[1]),
        .mem_size(memSize[1]), .mem_unsigned(memUnsigned[1]),
        .address(address[1]), .write_data(writeData[1]),
        .req_ready(reqReady[1]), .resp_valid(respValid[1]),
        .resp_err(respErr[1]), .read_data(readData[1])
    );

    function automatic int waitOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference: apply one access to the byte array and predict the response.
    function automatic void predict(
        input int d, input bit rd, input bit wr, input int size,
        input bit uns, input logic [31:0] addr, input logic [31:0] wd,
        output bit expErr, output logic [31:0] expData, output bit dk
    );
        int a;
        int n;
        longint v;
        a = int'(addr % DEPTH);
        n = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
        if (n == 0) expErr = 1'b1;
        else expErr = (a % n) != 0;
        if (expErr) begin
            lastData[d] = 32'd0;
            lastKnown[d] = 1'b1;
        end else begin
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    model[d][a+i] = int'((wd >> (8 * (n - 1 - i))) & 32'hFF);
                    known[d][a+i] = 1'b1;
                end
            end
            if (rd) begin
                v = 0;
                lastKnown[d] = 1'b1;
                for (int i = 0; i < n; i++) begin
                    v = v * 256 + longint'(model[d][a+i]);
                    if (!known[d][a+i]) lastKnown[d] = 1'b0;
                end
                if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                    v = v - (longint'(1) << (8 * n));
                lastData[d] = v[31:0];
            end
        end
        expData = lastData[d];
        dk = lastKnown[d];
    endfunction

    task automatic access(
        input int d, input bit rd, input bit wr, input logic [1:0] sz,
        input bit uns, input logic [31:0] addr, input logic [31:0] wd,
        input string name, output logic [31:0] got, output logic err
    );
        int k;
        bit expErr;
        bit dk;
        logic [31:0] expData;
        got = 32'hx;
        err = 1'bx;
        k = 0;
        while (reqReady[d] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (reqReady[d] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s dut%0d: req_ready got %b want 1", name, d, reqReady[d]);
            return;
        end
        memRead[d] = rd;
        memWrite[d] = wr;
        memSize[d] = sz;
        memUnsigned[d] = uns;
        address[d] = addr;
        writeData[d] = wd;
        @(posedge clk);
        predict(d, rd, wr, int'(sz), uns, addr, wd, expErr, expData, dk);
        @(negedge clk);
        memRead[d] = 1'b0;
        memWrite[d] = 1'b0;
        k = 0;
        while (respValid[d] !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (respValid[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s dut%0d: resp_valid got %b want 1", name, d, respValid[d]);
            return;
        end
        checks++;
        if (k != waitOf(d)) begin
            failures++;
            $display("FAIL %s dut%0d latency: got %0d want %0d", name, d, k, waitOf(d));
        end
        got = readData[d];
        err = respErr[d];
        checks++;
        if (respErr[d] !== expErr) begin
            failures++;
            $display("FAIL %s dut%0d resp_err @%h: got %b want %b", name, d, addr, respErr[d], expErr);
        end
        if (dk) begin
            checks++;
            if (readData[d] !== expData) begin
                failures++;
                $display("FAIL %s dut%0d read_data @%h: got %h want %h", name, d, addr, readData[d], expData);
            end
        end
    endtask

    task automatic release_reset();
        int n;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            lastData[d] = 32'd0;
            lastKnown[d] = 1'b1;
        end
`ifdef DMEM_CLEAR_EN
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (reqReady[0] === 1'b1) break;
        end
        checks++;
        if (n != DEPTH / 4) begin
            failures++;
            $display("FAIL clear_len: ready after %0d cycles want %0d", n, DEPTH / 4);
        end
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < DEPTH; a++) begin
                model[d][a] = 0;
                known[d][a] = 1'b1;
            end
`else
        n = 0;
        #1;
`endif
        checks++;
        if (reqReady[0] !== 1'b1 || reqReady[1] !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b%b want 11", reqReady[0], reqReady[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (respValid[d] !== 1'b0 || respErr[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_resp dut%0d: got v=%b e=%b want 0 0", d, respValid[d], respErr[d]);
            end
            checks++;
            if (readData[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_data dut%0d: got %h want 0", d, readData[d]);
            end
            checks++;
`ifdef DMEM_CLEAR_EN
            if (reqReady[d] !== 1'b0) begin
`else
            if (reqReady[d] !== 1'b1) begin
`endif
                failures++;
                $display("FAIL reset_ready dut%0d: got %b", d, reqReady[d]);
            end
        end
        release_reset();
    endtask

    task automatic test_basic();
        logic [31:0] got;
        logic e;
        access(0, 0, 1, 2'b10, 0, 32'h10, 32'h12345678, "sw", got, e);
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, "lw", got, e);
        checks++;
        if (got !== 32'h12345678) begin
            failures++;
            $display("FAIL lw_10: got %h want 12345678", got);
        end
        access(0, 1, 0, 2'b00, 1, 32'h11, 32'h0, "lbu", got, e);
        checks++;
        if (got !== 32'h00000034) begin
            failures++;
            $display("FAIL lbu_11: got %h want 00000034", got);
        end
        access(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, "lb", got, e);
        checks++;
        if (got !== 32'h00000012) begin
            failures++;
            $display("FAIL lb_10: got %h want 00000012", got);
        end
    endtask

    task automatic test_extension();
        logic [31:0] got;
        logic e;
        access(0, 0, 1, 2'b10, 0, 32'h20, 32'h0, "sw0", got, e);
        access(0, 0, 1, 2'b01, 0, 32'h20, 32'h0000F00D, "sh", got, e);
        access(0, 1, 0, 2'b01, 0, 32'h20, 32'h0, "lh", got, e);
        checks++;
        if (got !== 32'hFFFFF00D) begin
            failures++;
            $display("FAIL lh_20: got %h want FFFFF00D", got);
        end
        access(0, 1, 0, 2'b01, 1, 32'h20, 32'h0, "lhu", got, e);
        checks++;
        if (got !== 32'h0000F00D) begin
            failures++;
            $display("FAIL lhu_20: got %h want 0000F00D", got);
        end
        access(0, 0, 1, 2'b00, 0, 32'h23, 32'h80, "sb", got, e);
        access(0, 1, 0, 2'b00, 0, 32'h23, 32'h0, "lb23", got, e);
        checks++;
        if (got !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_23: got %h want FFFFFF80", got);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] got;
        logic e;
        access(0, 1, 0, 2'b10, 0, 32'h22, 32'h0, "lw22", got, e);
        checks++;
        if (e !== 1'b1 || got !== 32'd0) begin
            failures++;
            $display("FAIL lw_22_err: got e=%b d=%h want 1 0", e, got);
        end
        access(0, 0, 1, 2'b01, 0, 32'h21, 32'h0000BEEF, "sh21", got, e);
        checks++;
        if (e !== 1'b1 || got !== 32'd0) begin
            failures++;
            $display("FAIL sh_21_err: got e=%b d=%h want 1 0", e, got);
        end
        access(0, 1, 0, 2'b11, 0, 32'h0, 32'h0, "size11", got, e);
        checks++;
        if (e !== 1'b1 || got !== 32'd0) begin
            failures++;
            $display("FAIL size11_err: got e=%b d=%h want 1 0", e, got);
        end
        access(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, "lw20", got, e);
        checks++;
        if (got !== 32'hF00D0080) begin
            failures++;
            $display("FAIL lw_20_after_err: got %h want F00D0080", got);
        end
    endtask

    task automatic test_wrap_simul();
        logic [31:0] got;
        logic e;
        access(0, 0, 1, 2'b10, 0, 32'h104, 32'hAABBCCDD, "sw104", got, e);
        access(0, 1, 0, 2'b10, 0, 32'h04, 32'h0, "lw04", got, e);
        checks++;
        if (got !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL wrap_04: got %h want AABBCCDD", got);
        end
        access(0, 1, 1, 2'b10, 0, 32'h08, 32'h01020304, "rdwr08", got, e);
        checks++;
        if (got !== 32'h01020304) begin
            failures++;
            $display("FAIL rdwr_08: got %h want 01020304", got);
        end
        access(0, 0, 1, 2'b00, 1, 32'h08, 32'h000000EE, "sb_hold", got, e);
        checks++;
        if (got !== 32'h01020304) begin
            failures++;
            $display("FAIL write_hold: got %h want 01020304", got);
        end
    endtask

    task automatic test_wait_timing();
        logic [31:0] got;
        logic e;
        bit expErr;
        bit dk;
        logic [31:0] expData;
        int k;
        access(1, 0, 1, 2'b10, 0, 32'h30, 32'h5A5AA5A5, "sw30", got, e);
        memWrite[1] = 1'b1;
        memSize[1] = 2'b10;
        address[1] = 32'h30;
        writeData[1] = 32'hCAFEF00D;
        @(posedge clk);
        predict(1, 0, 1, 2, 0, 32'h30, 32'hCAFEF00D, expErr, expData, dk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            memWrite[1] = 1'b0;
            checks++;
            if (reqReady[1] !== 1'b0 || respValid[1] !== 1'b0) begin
                failures++;
                $display("FAIL wait_cycle%0d: got rdy=%b v=%b want 0 0", i, reqReady[1], respValid[1]);
            end
        end
        @(negedge clk);
        checks++;
        if (respValid[1] !== 1'b1 || reqReady[1] !== 1'b1) begin
            failures++;
            $display("FAIL wait_resp: got v=%b rdy=%b want 1 1", respValid[1], reqReady[1]);
        end
        memRead[1] = 1'b1;
        address[1] = 32'h30;
        @(posedge clk);
        predict(1, 1, 0, 2, 0, 32'h30, 32'h0, expErr, expData, dk);
        @(negedge clk);
        memRead[1] = 1'b0;
        checks++;
        if (reqReady[1] !== 1'b0 || respValid[1] !== 1'b0) begin
            failures++;
            $display("FAIL second_accept: got rdy=%b v=%b want 0 0", reqReady[1], respValid[1]);
        end
        k = 0;
        while (respValid[1] !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (respValid[1] !== 1'b1 || k != 3 || readData[1] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL second_resp: got v=%b k=%0d d=%h want 1 3 CAFEF00D", respValid[1], k, readData[1]);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] got;
        logic e;
        int n;
        access(1, 0, 1, 2'b10, 0, 32'h40, 32'h11223344, "sw40", got, e);
        memWrite[1] = 1'b1;
        memSize[1] = 2'b10;
        address[1] = 32'h40;
        writeData[1] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        memWrite[1] = 1'b0;
        checks++;
        if (reqReady[1] !== 1'b0) begin
            failures++;
            $display("FAIL midwait_accept: got rdy=%b want 0", reqReady[1]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (respValid[1] !== 1'b0) n++;
        end
        release_reset();
        for (int i = 0; i < 6; i++) begin
            if (respValid[0] !== 1'b0 || respValid[1] !== 1'b0) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL midwait_noresp: got %0d strobes want 0", n);
        end
        access(1, 1, 0, 2'b10, 0, 32'h40, 32'h0, "lw40", got, e);
        checks++;
`ifdef DMEM_CLEAR_EN
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL midwait_word: got %h want 00000000", got);
        end
        access(0, 1, 0, 2'b10, 0, 32'hFC, 32'h0, "lwFC", got, e);
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL clear_FC: got %h want 00000000", got);
        end
`else
        if (got !== 32'h11223344) begin
            failures++;
            $display("FAIL midwait_word: got %h want 11223344", got);
        end
`endif
    endtask

    task automatic test_random(input int d);
        logic [31:0] got;
        logic e;
        logic [31:0] a;
        logic [1:0] sz;
        int op;
        for (int w = 0; w < DEPTH / 4; w++)
            access(d, 0, 1, 2'b10, 0, 32'(w * 4), $urandom(), "prefill", got, e);
        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                else if (sz == 2'b10) a[1:0] = 2'b00;
            end
            op = int'($urandom_range(0, 2));
            access(d, op != 1, op != 0, sz, 1'($urandom_range(0, 1)),
                   a, $urandom(), "random", got, e);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            memRead[d] = 1'b0;
            memWrite[d] = 1'b0;
            memSize[d] = 2'b00;
            memUnsigned[d] = 1'b0;
            address[d] = 32'd0;
            writeData[d] = 32'd0;
        end
        test_reset();
        test_basic();
        test_extension();
        test_misalign();
        test_wrap_simul();
        test_wait_timing();
        test_reset_mid_wait();
        test_random(0);
        test_random(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
